// File: rtl/dbg_guv_pkg.sv
// Shared dbg_guv definitions: command payload width, route kinds, broadcast test.
// Also used by the governor's control FSM, so keep it free of router-specific details.
package dbg_guv_pkg;

   localparam int CMD_PAYLOAD_WIDTH = 29;

   typedef enum logic [1:0] {
      ROUTE_LOCAL,
      ROUTE_CHAIN,
      ROUTE_BOTH
   } route_t;

   // addr arrives zero-extended; only the low 'width' bits form the address field
   function automatic logic is_bcast(input logic [31:0] addr, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (addr & mask) == mask;
   endfunction

endpackage

// File: rtl/dbg_guv_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after the first push.
// Push refused when full (even with a same-cycle pop); pop ignored when empty.
module dbg_guv_cmd_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [AW:0]      level_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      level_d = level_q;
      if (push_ok && !pop_ok) begin
         level_d = level_q + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
         level_d = level_q - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         level_q <= level_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage needs no reset: level_q gates every read that matters.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/dbg_guv_cmd_router.sv
// Splits addressed debug commands into a local FWFT FIFO and a daisy-chain register, 1-cycle latency.
// Input ready is combinational on route, FIFO space and chain slot; broadcasts wait for both.
module dbg_guv_cmd_router
   import dbg_guv_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int MY_ADDR    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ADDR_WIDTH+CMD_PAYLOAD_WIDTH-1:0] cmd_in_TDATA,
   input  logic                                  cmd_in_TVALID,
   output logic                                  cmd_in_TREADY,
   output logic [CMD_PAYLOAD_WIDTH-1:0]          cmd_out_TDATA,
   output logic                                  cmd_out_TVALID,
   input  logic                                  cmd_out_TREADY,
   output logic [ADDR_WIDTH+CMD_PAYLOAD_WIDTH-1:0] chain_out_TDATA,
   output logic                                  chain_out_TVALID,
   input  logic                                  chain_out_TREADY,
   output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
   output logic [15:0]                           local_count
);

   localparam int WW = ADDR_WIDTH + CMD_PAYLOAD_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] MY_ADDR_L = ADDR_WIDTH'(MY_ADDR);

   logic [ADDR_WIDTH-1:0] addr;
   route_t                route;
   logic                  local_ok, chain_ok, route_rdy, in_hs;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                  chain_wr;
   logic                  chain_vld_q, chain_vld_d;
   logic [WW-1:0]         chain_dat_q;
   logic [15:0]           count_q, count_d;

   assign addr = cmd_in_TDATA[WW-1:CMD_PAYLOAD_WIDTH];

   always_comb begin
      route = ROUTE_CHAIN;
      if (addr == MY_ADDR_L) begin
         route = ROUTE_LOCAL;
      end else if (is_bcast(32'(addr), ADDR_WIDTH)) begin
         route = ROUTE_BOTH;
      end
   end

   assign local_ok = !fifo_full;
   assign chain_ok = !chain_vld_q || chain_out_TREADY;

   // A broadcast must see both slots free so it is never half-delivered.
   always_comb begin
      case (route)
         ROUTE_LOCAL: route_rdy = local_ok;
         ROUTE_BOTH:  route_rdy = local_ok && chain_ok;
         default:     route_rdy = chain_ok;
      endcase
   end

   assign cmd_in_TREADY = route_rdy && !rst;
   assign in_hs         = cmd_in_TVALID && cmd_in_TREADY;
   assign fifo_push     = in_hs && (route != ROUTE_CHAIN);
   assign chain_wr      = in_hs && (route != ROUTE_LOCAL);
   assign fifo_pop      = cmd_out_TVALID && cmd_out_TREADY;

   dbg_guv_cmd_fifo #(
      .WIDTH (CMD_PAYLOAD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (fifo_push),
      .push_dat_i (cmd_in_TDATA[CMD_PAYLOAD_WIDTH-1:0]),
      .pop_i      (fifo_pop),
      .head_o     (cmd_out_TDATA),
      .level_o    (fifo_level),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign cmd_out_TVALID = !fifo_empty;

   always_comb begin
      chain_vld_d = chain_vld_q;
      if (chain_wr) begin
         chain_vld_d = 1'b1;
      end else if (chain_out_TREADY) begin
         chain_vld_d = 1'b0;
      end
   end

   always_comb begin
      count_d = count_q;
      if (fifo_pop) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_vld_q <= 1'b0;
         count_q     <= '0;
      end else begin
         chain_vld_q <= chain_vld_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (chain_wr) chain_dat_q <= cmd_in_TDATA;
   end

   assign chain_out_TVALID = chain_vld_q;
   assign chain_out_TDATA  = chain_dat_q;
   assign local_count      = count_q;

endmodule

// File: tb/tb_dbg_guv_cmd_router.sv
// Bench for dbg_guv_cmd_router (MY_ADDR=3, 4-bit address, depth 4): vector table,
// random traffic and reset corner, all outputs checked each cycle against a queue model.
module tb_dbg_guv_cmd_router;

   logic        clk;
   logic        rst;
   logic [32:0] cmd_in_TDATA;
   logic        cmd_in_TVALID;
   logic        cmd_in_TREADY;
   logic [28:0] cmd_out_TDATA;
   logic        cmd_out_TVALID;
   logic        cmd_out_TREADY;
   logic [32:0] chain_out_TDATA;
   logic        chain_out_TVALID;
   logic        chain_out_TREADY;
   logic [2:0]  fifo_level;
   logic [15:0] local_count;

   dbg_guv_cmd_router #(
      .ADDR_WIDTH (4),
      .MY_ADDR    (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_in_TDATA     (cmd_in_TDATA),
      .cmd_in_TVALID    (cmd_in_TVALID),
      .cmd_in_TREADY    (cmd_in_TREADY),
      .cmd_out_TDATA    (cmd_out_TDATA),
      .cmd_out_TVALID   (cmd_out_TVALID),
      .cmd_out_TREADY   (cmd_out_TREADY),
      .chain_out_TDATA  (chain_out_TDATA),
      .chain_out_TVALID (chain_out_TVALID),
      .chain_out_TREADY (chain_out_TREADY),
      .fifo_level       (fifo_level),
      .local_count      (local_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: local queue mirrors FIFO contents, chain queue mirrors the chain register.
   logic [28:0] lq[$];
   logic [32:0] cq[$];
   logic [15:0] m_count = 16'd0;
   logic        m_lok, m_cok, m_rdy;
   logic [3:0]  m_addr;

   always @(negedge clk) begin
      chk("fifo_level", 64'(fifo_level), 64'(lq.size()));
      chk("cmd_vld", 64'(cmd_out_TVALID), 64'(lq.size() != 0));
      if (lq.size() != 0) chk("cmd_dat", 64'(cmd_out_TDATA), 64'(lq[0]));
      chk("chain_vld", 64'(chain_out_TVALID), 64'(cq.size() != 0));
      if (cq.size() != 0) chk("chain_dat", 64'(chain_out_TDATA), 64'(cq[0]));
      chk("local_count", 64'(local_count), 64'(m_count));

      m_addr = cmd_in_TDATA[32:29];
      m_lok  = lq.size() < 4;
      m_cok  = (cq.size() == 0) || chain_out_TREADY;
      if (rst)                m_rdy = 1'b0;
      else if (m_addr == 4'd3) m_rdy = m_lok;
      else if (m_addr == 4'hF) m_rdy = m_lok && m_cok;
      else                     m_rdy = m_cok;
      chk("in_rdy", 64'(cmd_in_TREADY), 64'(m_rdy));

      if (rst) begin
         lq.delete();
         cq.delete();
         m_count = 16'd0;
      end else begin
         if (lq.size() != 0 && cmd_out_TREADY) begin
            void'(lq.pop_front());
            m_count = m_count + 16'd1;
         end
         if (cq.size() != 0 && chain_out_TREADY) void'(cq.pop_front());
         if (cmd_in_TVALID && m_rdy) begin
            if (m_addr != 4'd3) cq.push_back(cmd_in_TDATA);
            if (m_addr == 4'd3 || m_addr == 4'hF) lq.push_back(cmd_in_TDATA[28:0]);
         end
      end
   end

   typedef struct {
      logic        vld;
      logic [3:0]  addr;
      logic [28:0] pay;
      logic        crdy;
      logic        chrdy;
      logic        exp_rdy;
      int          exp_lvl;
   } vec_t;

   vec_t vq[$];

   task automatic addv(input logic v, input logic [3:0] a, input logic [28:0] p,
                       input logic cr, input logic chr, input logic er, input int el);
      vec_t t;
      t.vld = v; t.addr = a; t.pay = p; t.crdy = cr; t.chrdy = chr;
      t.exp_rdy = er; t.exp_lvl = el;
      vq.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [28:0] p,
                        input logic cr, input logic chr);
      @(posedge clk);
      #1;
      cmd_in_TVALID    = v;
      cmd_in_TDATA     = {a, p};
      cmd_out_TREADY   = cr;
      chain_out_TREADY = chr;
      #1;
   endtask

   initial begin
      rst              = 1'b1;
      cmd_in_TVALID    = 1'b0;
      cmd_in_TDATA     = '0;
      cmd_out_TREADY   = 1'b0;
      chain_out_TREADY = 1'b0;

      // Ready must stay low during reset even for an acceptable local word.
      drive(1'b1, 4'd3, 29'h1, 1'b1, 1'b1);
      chk("rst_in_rdy", 64'(cmd_in_TREADY), 64'd0);
      drive(1'b0, 4'd0, 29'h0, 1'b1, 1'b1);
      chk("rst_fifo_level", 64'(fifo_level), 64'd0);
      chk("rst_cmd_vld", 64'(cmd_out_TVALID), 64'd0);
      chk("rst_chain_vld", 64'(chain_out_TVALID), 64'd0);
      chk("rst_local_count", 64'(local_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      //    vld  addr   payload       crdy chrdy rdy lvl
      addv(1, 4'd3, 29'h0000001, 1, 1, 1, 0);
      addv(1, 4'd3, 29'h0000002, 1, 1, 1, 1);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 1);
      addv(1, 4'd5, 29'h1ABCDEF, 1, 1, 1, 0);
      addv(0, 4'd0, 29'h0,       1, 0, 0, 0);
      addv(1, 4'hF, 29'h0000042, 1, 0, 0, 0);
      addv(1, 4'hF, 29'h0000042, 1, 0, 0, 0);
      addv(1, 4'hF, 29'h0000042, 1, 1, 1, 0);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 1);
      addv(0, 4'd0, 29'h0,       0, 1, 0, 0);
      addv(1, 4'd3, 29'h0000010, 0, 1, 1, 0);
      addv(1, 4'd3, 29'h0000011, 0, 1, 1, 1);
      addv(1, 4'd3, 29'h0000012, 0, 1, 1, 2);
      addv(1, 4'd3, 29'h0000013, 0, 1, 1, 3);
      addv(1, 4'd3, 29'h0000014, 0, 1, 0, 4);
      addv(1, 4'd3, 29'h0000014, 1, 1, 0, 4);
      addv(1, 4'd3, 29'h0000014, 0, 1, 1, 3);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 4);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 3);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 2);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 1);
      addv(0, 4'd0, 29'h0,       1, 1, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].vld, vq[i].addr, vq[i].pay, vq[i].crdy, vq[i].chrdy);
         chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vq[i].exp_lvl));
         if (vq[i].vld) chk($sformatf("vec%0d_in_rdy", i), 64'(cmd_in_TREADY), 64'(vq[i].exp_rdy));
      end
      chk("vec_local_count", 64'(local_count), 64'd8);
      chk("vec_chain_idle", 64'(chain_out_TVALID), 64'd0);

      // Random traffic with random back-pressure on both outputs.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] a;
         case ($urandom_range(0, 4))
            0: a = 4'd3;
            1: a = 4'hF;
            2: a = 4'd5;
            3: a = 4'd0;
            default: a = 4'($urandom);
         endcase
         drive($urandom_range(0, 3) != 0, a, 29'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 8; i++) drive(1'b0, 4'd0, 29'h0, 1'b1, 1'b1);

      // Reset with three local entries buffered and the chain register occupied.
      drive(1'b1, 4'd7, 29'h000000D, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 29'h000000A, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 29'h000000B, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 29'h000000C, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst              = 1'b1;
      cmd_in_TVALID    = 1'b1;
      cmd_in_TDATA     = {4'hF, 29'h0000099};
      chain_out_TREADY = 1'b1;
      #1;
      chk("pre_rst_level", 64'(fifo_level), 64'd3);
      chk("pre_rst_chain_vld", 64'(chain_out_TVALID), 64'd1);
      chk("rst_mid_in_rdy", 64'(cmd_in_TREADY), 64'd0);
      drive(1'b0, 4'd0, 29'h0, 1'b1, 1'b1);
      rst = 1'b0;
      chk("post_rst_level", 64'(fifo_level), 64'd0);
      chk("post_rst_cmd_vld", 64'(cmd_out_TVALID), 64'd0);
      chk("post_rst_chain_vld", 64'(chain_out_TVALID), 64'd0);
      chk("post_rst_count", 64'(local_count), 64'd0);
      drive(1'b1, 4'd3, 29'h0000077, 1'b0, 1'b1);
      chk("post_rst_in_rdy", 64'(cmd_in_TREADY), 64'd1);
      drive(1'b0, 4'd0, 29'h0, 1'b1, 1'b1);
      chk("post_rst_cmd_vld2", 64'(cmd_out_TVALID), 64'd1);
      chk("post_rst_cmd_dat", 64'(cmd_out_TDATA), 64'h77);
      for (int i = 0; i < 4; i++) drive(1'b0, 4'd0, 29'h0, 1'b1, 1'b1);
      chk("end_count", 64'(local_count), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/dbg_guv_cmd_router.md
# dbg_guv_cmd_router

Upstream command stage for a `dbg_guv` instance.
- Takes addressed command words from the host-side debug command chain.
- Keeps the words addressed to this instance, or broadcast, and buffers them in a small FIFO. It presents them to the governor's 29-bit `cmd_in` stream.
- Forwards every word not exclusively addressed to this instance, unchanged, to the next router in the daisy chain.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: width of the instance-address field above the 29-bit payload.
- `MY_ADDR`, 0: this instance's address. Must not equal the all-ones broadcast value.
- `FIFO_DEPTH`, 4: local command FIFO depth. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cmd_in_TDATA`  in  ADDR_WIDTH+29: command word. `{addr, payload[28:0]}`.
- `cmd_in_TVALID`  in  1: input word valid.
- `cmd_in_TREADY`  out  1: input word accepted.
- `cmd_out_TDATA`  out  29: payload to the governor's `cmd_in_TDATA`.
- `cmd_out_TVALID`  out  1: local command valid.
- `cmd_out_TREADY`  in  1: governor accepts the local command.
- `chain_out_TDATA`  out  ADDR_WIDTH+29: word forwarded to the next router, full width, unmodified.
- `chain_out_TVALID`  out  1: forwarded word valid.
- `chain_out_TREADY`  in  1: next router accepts the forwarded word.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: local FIFO occupancy.
- `local_count`  out  16: count of commands accepted by the governor, wrapping.

## Operation
- Route decode is combinational on `cmd_in_TDATA[ADDR_WIDTH+28:29]`:
  - `addr == MY_ADDR` → LOCAL.
  - `addr == all-ones` → BOTH.
  - any other address → CHAIN.
- `cmd_in_TREADY` depends on the route:
  - LOCAL: `local_ok`.
  - CHAIN: `chain_ok`.
  - BOTH: `local_ok && chain_ok`.
- Definitions:
  - `local_ok = (fifo_level < FIFO_DEPTH)`.
  - `chain_ok = !chain_out_TVALID || chain_out_TREADY`.
- BOTH is atomic: a broadcast word is never split, so it is taken by both destinations in the same cycle or by neither.
- Write into the local FIFO:
  - Occurs on input handshake with route LOCAL or BOTH.
  - Only `payload[28:0]` is stored.
- Write into the chain register:
  - Occurs on input handshake with route CHAIN or BOTH.
  - The full word is stored.
- Chain register behaviour:
  - Single-entry register.
  - Refills in the same cycle it drains, giving full throughput.
  - Holds its data stable while `chain_out_TVALID && !chain_out_TREADY`.
- Local FIFO:
  - Synchronous, first-word-fall-through.
  - `cmd_out_TVALID = (fifo_level != 0)`.
  - `cmd_out_TDATA` is the head entry.
  - Pop on `cmd_out_TVALID && cmd_out_TREADY`.
  - Push is refused at `fifo_level == FIFO_DEPTH`, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle at other levels leave `fifo_level` unchanged.
- `local_count` increments by 1 on each pop and wraps from 0xFFFF to 0.
- The router never modifies payload bits. Command semantics belong to the governor's control FSM.

## Timing
- Reset values of outputs, asserted in the cycle after `rst` is sampled high:
  - `cmd_out_TVALID=0`.
  - `chain_out_TVALID=0`.
  - `fifo_level=0`.
  - `local_count=0`.
  - `cmd_out_TDATA`/`chain_out_TDATA` are don't-care.
  - `cmd_in_TREADY=0` while `rst` is high.
- Reset mid-operation discards all buffered local and chained words. A broadcast held at `rst` is lost on both paths.
- Latency, input handshake at cycle N:
  - `cmd_out_TVALID` high at N+1 if the FIFO was empty.
  - `chain_out_TVALID` high at N+1.
- Throughput: one input word per cycle when downstream is always ready.
- `cmd_in_TREADY` is combinational from `cmd_in_TDATA` address, `fifo_level`, `chain_out_TVALID` and `chain_out_TREADY`. There is no path from `cmd_out_TREADY`.
- All outputs except `cmd_in_TREADY` are registered.

## Structure
- Shared package `dbg_guv_pkg`:
  - `CMD_PAYLOAD_WIDTH = 29`.
  - Route enum `route_t {ROUTE_LOCAL, ROUTE_CHAIN, ROUTE_BOTH}`.
  - Broadcast helper function `is_bcast(addr)`.
  - The package is shared with the governor's control FSM.
- One sub-module, `dbg_guv_cmd_fifo`:
  - Parameterised width/depth.
  - Synchronous FWFT FIFO.
  - Exposes `level`, `full`, `empty`.
- Route decode, chain register and counter live in the top module.

## Test plan
- Reset, then `MY_ADDR=3` with words `{3,0x0000001}`, `{3,0x0000002}`, `cmd_out_TREADY=1`:
  - `cmd_out` shows 0x0000001 and 0x0000002 at cycles N+1 and N+2.
  - `chain_out_TVALID` stays 0.
  - `local_count=2`.
- Word `{5,0x1ABCDEF}`:
  - Appears on `chain_out_TDATA` as `{5,0x1ABCDEF}` one cycle later.
  - `fifo_level` stays 0.
- Broadcast `{0xF,0x0000042}` with `chain_out_TREADY=0` and the chain register occupied:
  - `cmd_in_TREADY=0`.
  - Nothing is pushed into the FIFO.
  - After `chain_out_TREADY=1`, the word is delivered to both outputs exactly once.
- `cmd_out_TREADY=0` with 5 LOCAL words, `FIFO_DEPTH=4`:
  - `fifo_level` reaches 4 and `cmd_in_TREADY` drops on the 5th word.
  - A simultaneous pop at full does not admit the 5th word that cycle.
  - The FIFO drains in order.
- Random mix of LOCAL/CHAIN/BOTH words with random downstream back-pressure, checked against a scoreboard:
  - No loss, duplication or reordering per output.
  - `chain_out_TDATA` is stable while stalled.
- `rst` asserted with 3 entries buffered and the chain register full:
  - Next cycle: `fifo_level=0`, both TVALIDs 0, `local_count=0`.
  - A new word after reset routes normally.
